hazard_freeze_ctrl: RTL and testbench

//   Pipeline sequencing controller for the 5-stage core (IF/ID/EX/MEM/WB).
//   - Detects RAW hazards in ID against the EX and MEM stages and issues a load-use / no-forward stall.
//   - Issues a branch flush.
//   - Runs a freeze FSM that holds every pipeline register while the MEM stage waits on a

---
 rtl/hazard_freeze_ctrl.sv | 128 ++++++++++++
 tb/tb_hazard_freeze_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_freeze_ctrl.sv
// Pipeline sequencing controller: RAW-hazard stall, branch flush, SRAM-wait freeze FSM
// with timeout, and a saturating stall-cycle counter.
module hazard_freeze_ctrl #(
    parameter int REG_W    = 4,
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             forward_en,
    input  logic [REG_W-1:0] id_src1,
    input  logic [REG_W-1:0] id_src2,
    input  logic             id_two_src,
    input  logic [REG_W-1:0] ex_dest,
    input  logic             ex_wb_en,
    input  logic             ex_mem_r_en,
    input  logic [REG_W-1:0] mem_dest,
    input  logic             mem_wb_en,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             sram_ready,
    input  logic             stat_clr,
    output logic             hazard_stall,
    output logic             flush,
    output logic             freeze,
    output logic             mem_timeout,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_count
);

    localparam int WCNT_W = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]  stall_count_q, stall_count_d;

    logic hit_ex_s, hit_mem_s, raw_stall_s;
    logic freeze_s, timeout_s, hazard_stall_s, flush_s;

    // RAW hazard detection; R0 is an ordinary register here
    always_comb begin
        hit_ex_s    = ex_wb_en  & ((id_src1 == ex_dest)  | (id_two_src & (id_src2 == ex_dest)));
        hit_mem_s   = mem_wb_en & ((id_src1 == mem_dest) | (id_two_src & (id_src2 == mem_dest)));
        raw_stall_s = forward_en ? (ex_mem_r_en & hit_ex_s) : (hit_ex_s | hit_mem_s);
    end

    // Freeze FSM next state and wait counter
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        freeze_s   = 1'b0;
        timeout_s  = 1'b0;
        case (state_q)
            ST_RUN: begin
                freeze_s = mem_req & ~sram_ready;
                if (freeze_s) begin
                    state_d    = ST_WAIT;
                    wait_cnt_d = WCNT_W'(1);
                end else begin
                    wait_cnt_d = {WCNT_W{1'b0}};
                end
            end
            ST_WAIT: begin
                freeze_s = ~sram_ready;
                if (sram_ready) begin
                    state_d    = ST_RUN;
                    wait_cnt_d = {WCNT_W{1'b0}};
                end else if (wait_cnt_q == WCNT_W'(MAX_WAIT - 1)) begin
                    state_d = ST_ERR;
                end else begin
                    wait_cnt_d = wait_cnt_q + WCNT_W'(1);
                end
            end
            ST_ERR: begin
                freeze_s  = 1'b1;
                timeout_s = 1'b1;
            end
            default: begin
                state_d    = ST_RUN;
                wait_cnt_d = {WCNT_W{1'b0}};
            end
        endcase
    end

    // Output priority freeze > flush > stall; everything held low during reset
    always_comb begin
        flush_s        = branch_taken & ~freeze_s;
        hazard_stall_s = raw_stall_s & ~freeze_s & ~branch_taken;
        freeze         = rst & freeze_s;
        mem_timeout    = rst & timeout_s;
        flush          = rst & flush_s;
        hazard_stall   = rst & hazard_stall_s;
        state          = state_q;
        stall_count    = stall_count_q;
    end

    // Stall counter next value: clear wins, then saturating increment
    always_comb begin
        stall_count_d = stall_count_q;
        if (stat_clr) begin
            stall_count_d = {CNT_W{1'b0}};
        end else if ((hazard_stall_s | freeze_s) && !(&stall_count_q)) begin
            stall_count_d = stall_count_q + CNT_W'(1);
        end else begin
            stall_count_d = stall_count_q;
        end
    end

    // State, wait counter and statistics registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_RUN;
            wait_cnt_q    <= {WCNT_W{1'b0}};
            stall_count_q <= {CNT_W{1'b0}};
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            stall_count_q <= stall_count_d;
        end
    end

endmodule

// File: tb/tb_hazard_freeze_ctrl.sv
// Directed self-checking bench for hazard_freeze_ctrl (CNT_W=4 to reach saturation quickly).
module tb_hazard_freeze_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       forward_en, id_two_src, ex_wb_en, ex_mem_r_en, mem_wb_en;
    logic       branch_taken, mem_req, sram_ready, stat_clr;
    logic [3:0] id_src1, id_src2, ex_dest, mem_dest;
    logic       hazard_stall, flush, freeze, mem_timeout;
    logic [1:0] state;
    logic [3:0] stall_count;

    int total = 0;
    int bad   = 0;

    hazard_freeze_ctrl #(.REG_W(4), .MAX_WAIT(16), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .forward_en(forward_en),
        .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
        .ex_dest(ex_dest), .ex_wb_en(ex_wb_en), .ex_mem_r_en(ex_mem_r_en),
        .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .branch_taken(branch_taken),
        .mem_req(mem_req), .sram_ready(sram_ready), .stat_clr(stat_clr),
        .hazard_stall(hazard_stall), .flush(flush), .freeze(freeze),
        .mem_timeout(mem_timeout), .state(state), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        forward_en = 1'b0; id_two_src = 1'b0; ex_wb_en = 1'b0; ex_mem_r_en = 1'b0;
        mem_wb_en = 1'b0; branch_taken = 1'b0; mem_req = 1'b0; sram_ready = 1'b0;
        stat_clr = 1'b0; id_src1 = 4'd0; id_src2 = 4'd0; ex_dest = 4'd0; mem_dest = 4'd0;
    endtask

    task automatic post_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic load_use(input logic br);
        forward_en = 1'b1; ex_mem_r_en = 1'b1; ex_wb_en = 1'b1;
        ex_dest = 4'd3; id_src1 = 4'd3; branch_taken = br;
    endtask

    initial begin
        clear_inputs();
        rst = 1'b0;
        ex_wb_en = 1'b1; branch_taken = 1'b1; mem_req = 1'b1;
        #12;
        chk("rst_hs", 32'(hazard_stall), 32'd0);
        chk("rst_fl", 32'(flush), 32'd0);
        chk("rst_fz", 32'(freeze), 32'd0);
        chk("rst_mt", 32'(mem_timeout), 32'd0);
        chk("rst_st", 32'(state), 32'd0);
        chk("rst_cnt", 32'(stall_count), 32'd0);
        @(negedge clk);
        clear_inputs();
        rst = 1'b1;

        // load-use with forwarding
        @(negedge clk);
        load_use(1'b0);
        #1;
        chk("lu_hs", 32'(hazard_stall), 32'd1);
        chk("lu_fl", 32'(flush), 32'd0);
        chk("lu_fz", 32'(freeze), 32'd0);
        post_edge();
        chk("lu_cnt", 32'(stall_count), 32'd1);
        @(negedge clk);
        ex_mem_r_en = 1'b0;
        #1;
        chk("fwd_no_stall", 32'(hazard_stall), 32'd0);
        clear_inputs();
        ex_wb_en = 1'b1;
        #1;
        chk("r0_hit", 32'(hazard_stall), 32'd1);
        clear_inputs();
        forward_en = 1'b0; mem_wb_en = 1'b1; mem_dest = 4'd5;
        id_two_src = 1'b1; id_src2 = 4'd5; id_src1 = 4'd7;
        #1;
        chk("mem_src2_hit", 32'(hazard_stall), 32'd1);
        id_two_src = 1'b0;
        #1;
        chk("mem_src2_unused", 32'(hazard_stall), 32'd0);
        clear_inputs();
        post_edge();
        chk("cnt_hold", 32'(stall_count), 32'd1);

        @(negedge clk);
        stat_clr = 1'b1;
        post_edge();
        chk("clr_cnt", 32'(stall_count), 32'd0);

        // 4-cycle SRAM wait
        @(negedge clk);
        stat_clr = 1'b0; mem_req = 1'b1; sram_ready = 1'b0;
        #1;
        chk("w_fz0", 32'(freeze), 32'd1);
        chk("w_st0", 32'(state), 32'd0);
        for (int i = 1; i <= 3; i++) begin
            post_edge();
            chk("w_fz", 32'(freeze), 32'd1);
            chk("w_st", 32'(state), 32'd1);
        end
        post_edge();
        @(negedge clk);
        sram_ready = 1'b1;
        #1;
        chk("w_ready_fz", 32'(freeze), 32'd0);
        chk("w_ready_st", 32'(state), 32'd1);
        post_edge();
        chk("w_back_st", 32'(state), 32'd0);
        chk("w_cnt", 32'(stall_count), 32'd4);
        @(negedge clk);
        mem_req = 1'b0; sram_ready = 1'b1;
        #1;
        chk("ready_idle_fz", 32'(freeze), 32'd0);
        post_edge();
        chk("ready_idle_st", 32'(state), 32'd0);

        // branch priority
        @(negedge clk);
        clear_inputs();
        load_use(1'b1);
        #1;
        chk("br_fl", 32'(flush), 32'd1);
        chk("br_hs", 32'(hazard_stall), 32'd0);
        post_edge();
        chk("br_cnt", 32'(stall_count), 32'd4);
        @(negedge clk);
        mem_req = 1'b1; sram_ready = 1'b0;
        #1;
        chk("brfz_fl", 32'(flush), 32'd0);
        chk("brfz_hs", 32'(hazard_stall), 32'd0);
        chk("brfz_fz", 32'(freeze), 32'd1);
        post_edge();
        @(negedge clk);
        mem_req = 1'b0; sram_ready = 1'b1;
        #1;
        chk("brunfz_fl", 32'(flush), 32'd1);
        chk("brunfz_fz", 32'(freeze), 32'd0);
        post_edge();
        chk("brunfz_cnt", 32'(stall_count), 32'd5);

        // saturation and clear
        @(negedge clk);
        clear_inputs();
        load_use(1'b0);
        for (int i = 0; i < 20; i++) post_edge();
        chk("sat_cnt", 32'(stall_count), 32'd15);
        @(negedge clk);
        stat_clr = 1'b1;
        #1;
        chk("clr_stall_hs", 32'(hazard_stall), 32'd1);
        post_edge();
        chk("clr_wins", 32'(stall_count), 32'd0);

        // timeout
        @(negedge clk);
        clear_inputs();
        mem_req = 1'b1;
        for (int i = 0; i < 15; i++) post_edge();
        chk("to_st15", 32'(state), 32'd1);
        chk("to_mt15", 32'(mem_timeout), 32'd0);
        post_edge();
        chk("to_st16", 32'(state), 32'd2);
        chk("to_mt16", 32'(mem_timeout), 32'd1);
        chk("to_fz16", 32'(freeze), 32'd1);
        @(negedge clk);
        mem_req = 1'b0; sram_ready = 1'b1; branch_taken = 1'b1;
        post_edge();
        post_edge();
        chk("err_st", 32'(state), 32'd2);
        chk("err_fz", 32'(freeze), 32'd1);
        chk("err_fl", 32'(flush), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("arst_st", 32'(state), 32'd0);
        chk("arst_fz", 32'(freeze), 32'd0);
        chk("arst_mt", 32'(mem_timeout), 32'd0);
        chk("arst_fl", 32'(flush), 32'd0);
        chk("arst_cnt", 32'(stall_count), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
